// File: rtl/rocc_cmd_queue.sv
// Purpose: RoCC command queue; buffers issued custom commands and writes back in-order responses.
// Latency: issue accept -> cmd_valid_o one cycle later; response -> result_valid_o one cycle later.
// Backpressure: issue_ready_o drops on full queue, outstanding limit or flush; results are never stalled.
module rocc_cmd_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MAX_OUT       = 8,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [31:0]              instr_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [XLEN-1:0]          cmd_rs1_o,
  output logic [XLEN-1:0]          cmd_rs2_o,
  output logic [31:0]              cmd_instr_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [XLEN-1:0]          resp_data_i,
  output logic                     result_valid_o,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
  output logic                     exception_valid_o,
  output logic                     spurious_resp_o,
  output logic                     busy_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned TPTR_W = $clog2(MAX_OUT);
  localparam int unsigned IF_W   = $clog2(MAX_OUT + 1);
  localparam int unsigned SUM_W  = IF_W + 1;

  typedef struct packed {
    logic [31:0]              instr;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } cmd_t;

  // Command queue state
  cmd_t [DEPTH-1:0]     mem_q, mem_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Tag FIFO state: one entry per command handed to the accelerator
  logic [MAX_OUT-1:0][TRANS_ID_BITS-1:0] tag_id_q, tag_id_d;
  logic [MAX_OUT-1:0]   tag_kill_q, tag_kill_d;
  logic [TPTR_W-1:0]    tag_wr_q, tag_wr_d;
  logic [TPTR_W-1:0]    tag_rd_q, tag_rd_d;
  logic [IF_W-1:0]      inflight_q, inflight_d;

  // Writeback registers
  logic                     result_valid_q, result_valid_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic [TRANS_ID_BITS-1:0] result_id_q, result_id_d;
  logic                     spurious_q, spurious_d;

  logic             q_empty, q_full;
  logic [SUM_W-1:0] occupancy;
  logic             push, pop, resp_pop;

  function automatic logic [TPTR_W-1:0] tag_next(input logic [TPTR_W-1:0] p);
    return (p == TPTR_W'(MAX_OUT - 1)) ? '0 : p + TPTR_W'(1);
  endfunction

  // Handshake qualifiers and status outputs, all from registered state
  always_comb begin
    q_empty       = (cnt_q == '0);
    q_full        = (cnt_q == CNT_W'(DEPTH));
    occupancy     = SUM_W'(cnt_q) + SUM_W'(inflight_q);
    issue_ready_o = !flush_i && !q_full && (occupancy < SUM_W'(MAX_OUT));
    push          = issue_valid_i && issue_ready_o;
    pop           = !q_empty && cmd_ready_i;
    // A tag pushed this cycle is not yet counted, so a same-cycle response is spurious.
    resp_pop      = resp_valid_i && (inflight_q != '0);
  end

  assign cmd_valid_o       = !q_empty;
  assign cmd_rs1_o         = mem_q[rd_ptr_q].rs1;
  assign cmd_rs2_o         = mem_q[rd_ptr_q].rs2;
  assign cmd_instr_o       = mem_q[rd_ptr_q].instr;
  assign resp_ready_o      = 1'b1;
  assign exception_valid_o = 1'b0;
  assign busy_o            = !q_empty || (inflight_q != '0);
  assign result_valid_o    = result_valid_q;
  assign result_o          = result_q;
  assign result_trans_id_o = result_id_q;
  assign spurious_resp_o   = spurious_q;

  // Command queue next state: write at tail, read at head, flush drops everything
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q].instr    = instr_i;
      mem_d[wr_ptr_q].rs1      = operand_a_i;
      mem_d[wr_ptr_q].rs2      = operand_b_i;
      mem_d[wr_ptr_q].trans_id = trans_id_i;
      wr_ptr_d                 = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Tag FIFO next state: record IDs of dispatched commands, kill all on flush
  always_comb begin
    tag_id_d   = tag_id_q;
    tag_kill_d = tag_kill_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    inflight_d = inflight_q;
    if (pop) begin
      tag_id_d[tag_wr_q]   = mem_q[rd_ptr_q].trans_id;
      tag_kill_d[tag_wr_q] = 1'b0;
      tag_wr_d             = tag_next(tag_wr_q);
    end
    if (resp_pop) begin
      tag_rd_d = tag_next(tag_rd_q);
    end
    case ({pop, resp_pop})
      2'b10:   inflight_d = inflight_q + IF_W'(1);
      2'b01:   inflight_d = inflight_q - IF_W'(1);
      default: inflight_d = inflight_q;
    endcase
    // Inflight count is kept so killed responses still drain their tags.
    if (flush_i) begin
      tag_kill_d = '1;
    end
  end

  // Writeback next state: one-cycle result pulse for live tags, spurious pulse otherwise
  always_comb begin
    result_valid_d = resp_pop && !tag_kill_q[tag_rd_q] && !flush_i;
    result_d       = result_q;
    result_id_d    = result_id_q;
    if (result_valid_d) begin
      result_d    = resp_data_i;
      result_id_d = tag_id_q[tag_rd_q];
    end
    spurious_d = resp_valid_i && (inflight_q == '0);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      tag_id_q       <= '0;
      tag_kill_q     <= '0;
      tag_wr_q       <= '0;
      tag_rd_q       <= '0;
      inflight_q     <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_id_q    <= '0;
      spurious_q     <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      tag_id_q       <= tag_id_d;
      tag_kill_q     <= tag_kill_d;
      tag_wr_q       <= tag_wr_d;
      tag_rd_q       <= tag_rd_d;
      inflight_q     <= inflight_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_id_q    <= result_id_d;
      spurious_q     <= spurious_d;
    end
  end

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Purpose: scoreboard bench for rocc_cmd_queue driving directed issue/response scenarios.
// Latency: expects commands one cycle after accept and results one cycle after response.
// Backpressure: bench toggles cmd_ready_i; results are consumed every cycle.
module tb_rocc_cmd_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [63:0] operand_a_i;
  logic [63:0] operand_b_i;
  logic [31:0] instr_i;
  logic [2:0]  trans_id_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [63:0] cmd_rs1_o;
  logic [63:0] cmd_rs2_o;
  logic [31:0] cmd_instr_o;
  logic        resp_valid_i;
  logic        resp_ready_o;
  logic [63:0] resp_data_i;
  logic        result_valid_o;
  logic [63:0] result_o;
  logic [2:0]  result_trans_id_o;
  logic        exception_valid_o;
  logic        spurious_resp_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  rocc_cmd_queue #(.DEPTH(4), .MAX_OUT(8), .XLEN(64), .TRANS_ID_BITS(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .instr_i(instr_i), .trans_id_i(trans_id_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_rs1_o(cmd_rs1_o), .cmd_rs2_o(cmd_rs2_o), .cmd_instr_o(cmd_instr_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o), .resp_data_i(resp_data_i),
    .result_valid_o(result_valid_o), .result_o(result_o),
    .result_trans_id_o(result_trans_id_o), .exception_valid_o(exception_valid_o),
    .spurious_resp_o(spurious_resp_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } cmd_exp_t;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] data;
    int          due;
  } res_exp_t;

  cmd_exp_t exp_cmd[$];
  res_exp_t exp_res[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int spur_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: pop expected command/result whenever the DUT presents one
  initial begin
    cmd_exp_t ce;
    res_exp_t re;
    forever begin
      @(negedge clk_i);
      if (rst_ni && cmd_valid_o && cmd_ready_i) begin
        if (exp_cmd.size() == 0) begin
          check("cmd_unexpected", {63'd0, cmd_valid_o}, 64'd0);
        end else begin
          ce = exp_cmd.pop_front();
          check("cmd_rs1", cmd_rs1_o, ce.rs1);
          check("cmd_rs2", cmd_rs2_o, ce.rs2);
          check("cmd_instr", {32'd0, cmd_instr_o}, {32'd0, ce.instr});
        end
      end
      if (result_valid_o) begin
        if (exp_res.size() == 0) begin
          check("result_unexpected", {63'd0, result_valid_o}, 64'd0);
        end else begin
          re = exp_res.pop_front();
          check("result_data", result_o, re.data);
          check("result_id", {61'd0, result_trans_id_o}, {61'd0, re.id});
          check("result_cycle", 64'(cyc), 64'(re.due));
        end
      end
      if (spurious_resp_o) spur_seen++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_one(input logic [2:0] id);
    int n;
    n = 0;
    issue_valid_i = 1'b1;
    operand_a_i   = 64'h1000 + 64'(id);
    operand_b_i   = 64'h2000 + 64'(id);
    instr_i       = 32'h0000_000B | (32'(id) << 7);
    trans_id_i    = id;
    @(negedge clk_i);
    while (!issue_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!issue_ready_o) begin
      check("issue_ready_timeout", {63'd0, issue_ready_o}, 64'd1);
    end else begin
      exp_cmd.push_back('{instr_i, operand_a_i, operand_b_i});
    end
    @(posedge clk_i);
    #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic send_resp(input logic [63:0] d, input bit expect_res, input logic [2:0] id);
    resp_valid_i = 1'b1;
    resp_data_i  = d;
    if (expect_res) exp_res.push_back('{id, d, cyc + 1});
    tick();
    resp_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst_ni = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; cmd_ready_i = 1'b0;
    resp_valid_i = 1'b0; resp_data_i = '0; operand_a_i = '0; operand_b_i = '0;
    instr_i = '0; trans_id_i = '0;

    // Reset state
    tick(); tick();
    check("rst_cmd_valid", {63'd0, cmd_valid_o}, 64'd0);
    check("rst_issue_ready", {63'd0, issue_ready_o}, 64'd1);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_result_valid", {63'd0, result_valid_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_spurious", {63'd0, spurious_resp_o}, 64'd0);
    check("resp_ready", {63'd0, resp_ready_o}, 64'd1);
    check("exception", {63'd0, exception_valid_o}, 64'd0);
    rst_ni = 1'b1;
    tick();

    // Back-to-back: IDs 1-4, responses 0xA..0xD
    cmd_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) issue_one(3'(i));
    tick(); tick();
    for (int i = 1; i <= 4; i++) send_resp(64'h9 + 64'(i), 1'b1, 3'(i));
    tick(); tick();
    check("b2b_busy", {63'd0, busy_o}, 64'd0);

    // Backpressure: queue fills, head holds, then drains one per cycle
    cmd_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) issue_one(3'(i));
    check("bp_issue_ready_full", {63'd0, issue_ready_o}, 64'd0);
    check("bp_cmd_valid", {63'd0, cmd_valid_o}, 64'd1);
    check("bp_head_rs1", cmd_rs1_o, 64'h1001);
    tick(); tick(); tick();
    check("bp_head_hold", cmd_rs1_o, 64'h1001);
    check("bp_head_hold_instr", {32'd0, cmd_instr_o}, 64'h0000_008B);
    cmd_ready_i = 1'b1;
    tick();
    check("bp_one_pop", cmd_rs1_o, 64'h1002);
    tick(); tick(); tick();
    check("bp_drained", {63'd0, cmd_valid_o}, 64'd0);
    for (int i = 1; i <= 4; i++) send_resp(64'h10 + 64'(i), 1'b1, 3'(i));
    tick();

    // Outstanding limit: 8 commands, no responses
    for (int i = 0; i < 8; i++) issue_one(3'(i));
    check("max_ready_after8", {63'd0, issue_ready_o}, 64'd0);
    tick();
    check("max_queue_empty", {63'd0, cmd_valid_o}, 64'd0);
    check("max_ready_limit", {63'd0, issue_ready_o}, 64'd0);
    check("max_busy", {63'd0, busy_o}, 64'd1);
    send_resp(64'h100, 1'b1, 3'd0);
    check("max_ready_restored", {63'd0, issue_ready_o}, 64'd1);
    for (int i = 1; i < 8; i++) send_resp(64'h100 + 64'(i), 1'b1, 3'(i));
    tick();
    check("max_busy_done", {63'd0, busy_o}, 64'd0);

    // Flush: 2 in flight, 2 queued
    issue_one(3'd1); issue_one(3'd2);
    tick();
    cmd_ready_i = 1'b0;
    issue_one(3'd3); issue_one(3'd4);
    flush_i = 1'b1;
    #1;
    check("flush_issue_ready", {63'd0, issue_ready_o}, 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    exp_cmd.delete();
    check("flush_queue_empty", {63'd0, cmd_valid_o}, 64'd0);
    check("flush_busy_inflight", {63'd0, busy_o}, 64'd1);
    s0 = spur_seen;
    send_resp(64'hDEAD, 1'b0, 3'd0);
    send_resp(64'hBEEF, 1'b0, 3'd0);
    tick();
    check("flush_busy_after", {63'd0, busy_o}, 64'd0);
    check("flush_no_spurious", 64'(spur_seen - s0), 64'd0);

    // Spurious response on an idle block
    s0 = spur_seen;
    send_resp(64'h55, 1'b0, 3'd0);
    check("spur_pulse", {63'd0, spurious_resp_o}, 64'd1);
    check("spur_no_result", {63'd0, result_valid_o}, 64'd0);
    tick();
    check("spur_pulse_end", {63'd0, spurious_resp_o}, 64'd0);
    check("spur_count", 64'(spur_seen - s0), 64'd1);

    // Response in the same cycle as the first command pop is spurious
    cmd_ready_i = 1'b1;
    issue_one(3'd5);
    send_resp(64'h66, 1'b0, 3'd0);
    check("samecyc_spurious", {63'd0, spurious_resp_o}, 64'd1);
    check("samecyc_busy", {63'd0, busy_o}, 64'd1);
    send_resp(64'h77, 1'b1, 3'd5);
    tick();
    check("samecyc_busy_done", {63'd0, busy_o}, 64'd0);

    // Reset mid-burst with 3 entries queued
    cmd_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) issue_one(3'(i));
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    exp_cmd.delete();
    check("midrst_cmd_valid", {63'd0, cmd_valid_o}, 64'd0);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_issue_ready", {63'd0, issue_ready_o}, 64'd1);
    send_resp(64'h99, 1'b0, 3'd0);
    check("midrst_spurious", {63'd0, spurious_resp_o}, 64'd1);
    tick(); tick();

    check("sb_results_left", 64'(exp_res.size()), 64'd0);
    check("sb_cmds_left", 64'(exp_cmd.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rocc_cmd_queue.md
ROCC_CMD_QUEUE -- requirements
Module: rocc_cmd_queue

Interface
REQ-001 The block SHALL have one clock, `clk_i`, and a synchronous active-low reset, `rst_ni`; all state SHALL update on the rising edge of `clk_i`.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- `DEPTH`, 4, command queue entries; power of 2, >=2.
- `MAX_OUT`, 8, maximum queued plus in-flight commands; >=`DEPTH`.
- `XLEN`, 64, operand and result width.
- `TRANS_ID_BITS`, 3, transaction-ID width.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- `clk_i`, in, 1, clock.
- `rst_ni`, in, 1, synchronous active-low reset.
- `flush_i`, in, 1, pipeline flush.
- `issue_valid_i`, in, 1, issue offers a command.
- `issue_ready_o`, out, 1, block accepts a command.
- `operand_a_i`, in, `XLEN`, rs1 value.
- `operand_b_i`, in, `XLEN`, rs2 value.
- `instr_i`, in, 32, custom instruction word.
- `trans_id_i`, in, `TRANS_ID_BITS`, scoreboard ID.
- `cmd_valid_o`, out, 1, command offered to the accelerator.
- `cmd_ready_i`, in, 1, accelerator accepts the command.
- `cmd_rs1_o`, out, `XLEN`, command rs1.
- `cmd_rs2_o`, out, `XLEN`, command rs2.
- `cmd_instr_o`, out, 32, command instruction word.
- `resp_valid_i`, in, 1, accelerator response valid.
- `resp_ready_o`, out, 1, response accepted.
- `resp_data_i`, in, `XLEN`, response data.
- `result_valid_o`, out, 1, writeback valid.
- `result_o`, out, `XLEN`, writeback data.
- `result_trans_id_o`, out, `TRANS_ID_BITS`, writeback ID.
- `exception_valid_o`, out, 1, exception flag.
- `spurious_resp_o`, out, 1, one-cycle pulse for a response with nothing in flight.
- `busy_o`, out, 1, queued or in-flight work exists.

Function
REQ-004 Command queue: a FIFO of `DEPTH` entries, each {`instr`, `rs1`, `rs2`, `trans_id`}; a push SHALL occur on `issue_valid_i` && `issue_ready_o`.
REQ-005 `issue_ready_o` SHALL equal !`flush_i` && !queue_full && (queued+inflight < `MAX_OUT`), computed from registered state only; it SHALL NOT depend on `cmd_ready_i`.
REQ-006 `cmd_valid_o` SHALL equal !queue_empty; `cmd_rs1_o`, `cmd_rs2_o` and `cmd_instr_o` SHALL present the head entry; there SHALL be no bypass, so minimum latency is accept at cycle N -> `cmd_valid_o` at cycle N+1.
REQ-007 The head SHALL stay stable while `cmd_valid_o` && !`cmd_ready_i`; a pop SHALL occur on `cmd_valid_o` && `cmd_ready_i`.
REQ-008 Simultaneous push and pop SHALL be allowed at any occupancy except full (no push when full) and SHALL leave the occupancy unchanged; read and write pointers SHALL wrap modulo `DEPTH`.
REQ-009 Tag FIFO: `MAX_OUT` entries of {`trans_id`, `kill`}; a command pop SHALL push {head `trans_id`, kill=0}; the inflight count SHALL be +1 on a command pop and -1 on an accepted response, and SHALL be unchanged when both occur.
REQ-010 `resp_ready_o` SHALL be constant 1; responses SHALL be in order, and each response SHALL match the oldest tag.
REQ-011 When `resp_valid_i` is high and inflight>0, the block SHALL pop the tag; if kill=0, then in the next cycle `result_valid_o`=1, `result_o`=the registered `resp_data_i`, and `result_trans_id_o`=tag `trans_id`; if kill=1, no result SHALL be produced.
REQ-012 `result_valid_o` SHALL be a single-cycle pulse per response and SHALL have no backpressure.
REQ-013 When `resp_valid_i` is high and inflight==0, the response SHALL be dropped, `spurious_resp_o`=1 in the next cycle, and no state SHALL change.
REQ-014 A response arriving in the same cycle as a command pop with inflight==0 SHALL be treated as spurious, because the new tag is not visible until the next cycle.
REQ-015 On `flush_i`=1 the block SHALL:
- empty the command queue at the clock edge;
- set kill=1 on every tag-FIFO entry, including a tag pushed by a command handshake in the same cycle;
- suppress a result for any response popped in the flush cycle;
- leave the inflight count intact, so that killed responses are still drained.
REQ-016 `flush_i` SHALL NOT clear `result_valid_o` if that output was already registered before the flush edge.
REQ-017 `exception_valid_o` SHALL be constant 0.
REQ-018 `busy_o` SHALL equal !queue_empty || inflight!=0.

Reset
REQ-019 On a clock edge with `rst_ni`=0 the block SHALL:
- empty both FIFOs;
- zero the pointers and counts;
- drive `result_valid_o`=0, `spurious_resp_o`=0, `result_o`=0 and `result_trans_id_o`=0.
REQ-020 During and immediately after reset, `cmd_valid_o`=0, `issue_ready_o`=1 (when `flush_i`=0) and `busy_o`=0.
REQ-021 Reset mid-operation SHALL discard all queued and in-flight state with no result emitted; a later response SHALL then be spurious.

Verification
REQ-022 The bench SHALL cover each of the following directed scenarios:
- Back-to-back: 4 issues with IDs 1-4, `cmd_ready_i`=1, responses 0xA..0xD -> results in order, IDs 1-4, each one cycle after its response.
- Backpressure: `cmd_ready_i`=0 with 4 issues -> `issue_ready_o`=0 after the 4th; `cmd_*` holds the ID-1 entry; releasing it pops one entry per cycle.
- `MAX_OUT` limit with `DEPTH`=4, `MAX_OUT`=8: 8 commands sent, no responses -> `issue_ready_o`=0 while the queue is not full; the first response restores `issue_ready_o`=1.
- Flush: 2 commands in flight plus 2 queued, then `flush_i` -> the queue empties, 2 later responses give no `result_valid_o`, then `busy_o`=0.
- Spurious: `resp_valid_i` with an idle block -> `spurious_resp_o` pulses once; `result_valid_o` stays 0.
- Reset mid-burst: `rst_ni`=0 for one cycle with 3 entries queued -> `cmd_valid_o`=0 and `busy_o`=0 on the next cycle.
